program_loader: RTL and testbench

Boot-time loader upstream of the `beetlejuice` core. It receives a framed program image as a byte stream from the UART receiver and writes it word by word into instruction memory. It holds the core in reset until a complete frame with a valid checksum has been written. It drives the core's `rst` through `core_rst`.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/program_loader_word_packer.sv | 39 +++
 rtl/program_loader.sv | 178 +++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_t : loader FSM encoding
//   SYNC_BYTE      : frame start marker
//   LEN_W          : width of the frame word-count field
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

endpackage

// File: rtl/program_loader_word_packer.sv
// word_packer: assembles four bytes, LSB first, into one 32-bit word.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart assembly at byte 0 (used when a new length is taken)
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word        : assembled word, meaningful when word_done is high
//   word_done   : the byte consumed this cycle completes a word
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  // Only three bytes need storing; the fourth is taken straight from the
  // input so the completed word is available in the same cycle it arrives.
  logic [23:0] sr_q;
  logic [1:0]  cnt_q;

  assign word_done = byte_valid && (cnt_q == 2'd3);
  assign word      = {byte_data, sr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (byte_valid) begin
      sr_q  <= {byte_data, sr_q[23:8]};
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed program image as a byte stream and
// writes it word by word into instruction memory, holding the core in reset
// until a complete frame with a matching XOR checksum has been written.
// Frame: 0xA5, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CHK.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_data     : received byte
//   in_valid    : in_data is valid
//   in_ready    : loader accepts a byte (low only in DONE)
//   imem_we     : registered one-cycle write strobe
//   imem_addr   : registered word address of the write
//   imem_wdata  : registered write data
//   core_rst    : reset to the core, high until the image is verified
//   done        : image loaded and verified (sticky until rst)
//   error       : last frame failed (cleared by the next sync byte)
//   dbg_state   : current FSM state
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends only on the state register, never on in_valid, and the
// sender must hold in_data stable while in_valid is high and no transfer has
// happened.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output loader_state_t     dbg_state
);

  // Counter only needs to hold 0..TIMEOUT-1: reaching the limit leaves the
  // counting states on that same edge.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Largest legal word count is the full memory capacity.
  localparam logic [LEN_W:0] CAP = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        xor_q;
  logic [TW-1:0]     tmo_q;

  logic              acc;
  logic              counting;
  logic              tmo_hit;
  logic [LEN_W-1:0]  len_full;
  logic              oversize;
  logic              last_word;
  logic              pk_clear;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic              pk_done;

  assign in_ready  = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign core_rst  = !done;
  assign dbg_state = state_q;

  assign acc       = in_valid && in_ready;
  assign counting  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHECK);
  // An accepted byte in the same cycle takes priority over the timeout.
  assign tmo_hit   = (TIMEOUT != 0) && counting && !acc && (tmo_q == TMO_LAST);

  assign len_full  = {in_data, len_lo_q};
  assign oversize  = {1'b0, len_full} > CAP;
  assign last_word = (wcnt_q == len_q - LEN_W'(1));

  assign pk_clear  = acc && (state_q == ST_LEN_HI);
  assign pk_valid  = acc && (state_q == ST_DATA);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .word       (pk_word),
    .word_done  (pk_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && (in_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (acc) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (acc) begin
          if (len_full == '0)  state_d = ST_CHECK;
          else if (oversize)   state_d = ST_ERROR;
          else                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_done && last_word) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (acc) state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        if (acc && (in_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      xor_q      <= '0;
      tmo_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state_q <= state_d;
      imem_we <= 1'b0;

      if (!counting || acc) tmo_q <= '0;
      else                  tmo_q <= tmo_q + TW'(1);

      if (acc) begin
        case (state_q)
          ST_LEN_LO: len_lo_q <= in_data;
          ST_LEN_HI: begin
            // Cleared for every length, including N = 0, so an empty frame
            // is checked against a zero checksum.
            len_q  <= len_full;
            wcnt_q <= '0;
            addr_q <= '0;
            xor_q  <= '0;
          end
          ST_DATA: begin
            xor_q <= xor_q ^ in_data;
            if (pk_done) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_q;
              imem_wdata <= pk_word;
              addr_q     <= addr_q + ADDR_W'(1);
              wcnt_q     <= wcnt_q + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader (ADDR_W = 4, TIMEOUT = 16).
module tb_program_loader;
  import loader_pkg::*;

  localparam int AW  = 4;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;
  loader_state_t dbg_state;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write pulse is matched against the expected queue.
  always @(posedge clk) begin
    logic [AW+31:0] e;
    #1;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[AW+31:32]));
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 required 1 within 40 cycles at %0t", $time);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Asserts rst mid-cycle and checks outputs before the next clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_ready",   32'(in_ready),  32'd1);
    check("rst_imem_we",    32'(imem_we),   32'd0);
    check("rst_imem_addr",  32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata,     32'd0);
    check("rst_core_rst",   32'(core_rst),  32'd1);
    check("rst_done",       32'(done),      32'd0);
    check("rst_error",      32'(error),     32'd0);
    check("rst_state",      32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Nominal two-word frame. XOR of 93 00 50 00 33 81 10 00 is 0x61.
  task automatic nominal_frame(input logic [7:0] chk, input bit expect_ok);
    expect_write(4'd0, 32'h00500093);
    expect_write(4'd1, 32'h00108133);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00500093);
    send_word(32'h00108133);
    check("core_rst_before_chk", 32'(core_rst), 32'd1);
    send_byte(chk);
    in_valid = 1'b0;
    check("done_after_chk",     32'(done),     expect_ok ? 32'd1 : 32'd0);
    check("core_rst_after_chk", 32'(core_rst), expect_ok ? 32'd0 : 32'd1);
    check("error_after_chk",    32'(error),    expect_ok ? 32'd0 : 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    logic [7:0]  x;

    @(posedge clk); #1;
    do_reset();

    // Nominal load, then DONE ignores the stream.
    nominal_frame(8'h61, 1'b1);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("done_in_ready", 32'(in_ready), 32'd0);
    end
    check("done_sticky", 32'(done), 32'd1);
    in_valid = 1'b0;

    // Bad checksum, then a valid frame recovers.
    do_reset();
    nominal_frame(8'h23, 1'b0);
    check("err_state", 32'(dbg_state), 32'(ST_ERROR));
    send_byte(8'h5A);  // non-sync byte discarded in ERROR
    check("err_sticky", 32'(error), 32'd1);
    in_valid = 1'b0;
    nominal_frame(8'h61, 1'b1);

    // Oversize: N = 17 exceeds 16 words.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h00);
    in_valid = 1'b0;
    check("oversize_error", 32'(error),     32'd1);
    check("oversize_state", 32'(dbg_state), 32'(ST_ERROR));
    send_word(32'h44332211);
    in_valid = 1'b0;
    check("oversize_core_rst", 32'(core_rst), 32'd1);

    // Full capacity: N = 16, addresses 0..15, then CHECK.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      w = 32'h13579BDF + k * 32'h01010101;
      expect_write(AW'(k), w);
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
    check("full_state_check", 32'(dbg_state), 32'(ST_CHECK));
    send_byte(x);
    in_valid = 1'b0;
    check("full_done", 32'(done), 32'd1);

    // Timeout: idle after two data bytes.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk); #1;
      if (k == TMO - 1) check("tmo_not_yet", 32'(error), 32'd0);
      if (k == TMO)     check("tmo_error",   32'(error), 32'd1);
    end

    // Reset mid-DATA after 5 data bytes, then a full frame from address 0.
    do_reset();
    expect_write(4'd0, 32'hDDCCBBAA);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'hDDCCBBAA);
    send_byte(8'hEE);
    do_reset();
    nominal_frame(8'h61, 1'b1);

    // Zero-length frame.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done",     32'(done),     32'd1);
    check("zero_core_rst", 32'(core_rst), 32'd0);
    in_data  = 8'h77;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("zero_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    repeat (4) @(posedge clk);
    #2;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
